// File: rtl/hmcs_pkg.sv
// Shared types and constants for the HMCS44A interrupt/timer controller.
// Mask commands SEIM/REIM pick their target mask with cmd_data[1:0] (0=im0, 1=im1, 2=tm).
package hmcs_pkg;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'h0,
        CMD_SEIE  = 4'h1,
        CMD_REIE  = 4'h2,
        CMD_SEIF0 = 4'h3,
        CMD_REIF0 = 4'h4,
        CMD_SEIF1 = 4'h5,
        CMD_REIF1 = 4'h6,
        CMD_SETF  = 4'h7,
        CMD_RETF  = 4'h8,
        CMD_SECF  = 4'h9,
        CMD_RECF  = 4'hA,
        CMD_SEIM  = 4'hB,
        CMD_REIM  = 4'hC,
        CMD_LTI   = 4'hD,
        CMD_LTA   = 4'hE
    } intc_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERVICE
    } intc_state_e;

    localparam logic [1:0] SRC_INT0  = 2'd0;
    localparam logic [1:0] SRC_INT1  = 2'd1;
    localparam logic [1:0] SRC_TIMER = 2'd2;

    localparam logic [10:0] VEC_INT0_DEF  = 11'h03F;
    localparam logic [10:0] VEC_INT1_DEF  = 11'h03F;
    localparam logic [10:0] VEC_TIMER_DEF = 11'h13F;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
    endfunction

endpackage

// File: rtl/hmcs_timer.sv
// Prescaler plus 4-bit timer/counter; a load always beats a same-cycle increment.
module hmcs_timer #(
    parameter int PRESCALE_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cf,
    input  logic       cnt_edge,
    input  logic       load,
    input  logic [3:0] load_data,
    output logic [3:0] counter,
    output logic       ovf
);

    logic [PRESCALE_W-1:0] prescaler;
    logic                  tick;
    logic                  inc;

    assign tick = ce && (&prescaler);
    assign inc  = cf ? cnt_edge : tick;
    assign ovf  = inc && !load && (counter == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            counter   <= 4'h0;
        end else begin
            if (ce) begin
                if (load)
                    prescaler <= '0;
                else
                    prescaler <= prescaler + 1'b1;
            end
            if (load)
                counter <= load_data;
            else if (inc)
                counter <= counter + 4'd1;
        end
    end

endmodule

// File: rtl/hmcs_intc.sv
// HMCS44A interrupt controller: input sync, flags/masks, priority and irq/ack FSM.
// Optional majority glitch filter on int0/int1 when HMCS_INTC_GLITCH_FILTER_EN is defined.
module hmcs_intc import hmcs_pkg::*; #(
    parameter int          PRESCALE_W = 6,
    parameter logic [10:0] VEC_INT0   = VEC_INT0_DEF,
    parameter logic [10:0] VEC_INT1   = VEC_INT1_DEF,
    parameter logic [10:0] VEC_TIMER  = VEC_TIMER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        int0,
    input  logic        int1,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_data,
    output logic [3:0]  counter,
    output logic [4:0]  flags,
    output logic [2:0]  req,
    output logic        irq,
    output logic [10:0] irq_vec,
    input  logic        irq_ack,
    input  logic        rtni
);

    logic [1:0]  sync0, sync1;
    logic        in0_clean, in1_clean;
    logic        in0_prev, in1_prev;
    logic        fall0, fall1;
    logic        if0, if1, tf;
    logic        im0, im1, tm;
    logic        ie, cf;
    logic        tmr_ovf;
    logic [2:0]  pend;
    logic [1:0]  win_src;
    logic [10:0] win_vec;
    logic [1:0]  winner;
    logic [2:0]  ack_clr;
    intc_state_e state;
    intc_cmd_e   cmd;

    logic c_seie, c_reie, c_seif0, c_reif0, c_seif1, c_reif1;
    logic c_setf, c_retf, c_secf, c_recf, c_seim, c_reim, c_load;
    logic ack_take, svc_exit;

    // Idle-high reset values keep reset release from looking like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 2'b11;
            sync1 <= 2'b11;
        end else begin
            sync0 <= {sync0[0], int0};
            sync1 <= {sync1[0], int1};
        end
    end

`ifdef HMCS_INTC_GLITCH_FILTER_EN
    logic [2:0] hist0, hist1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist0 <= 3'b111;
            hist1 <= 3'b111;
        end else begin
            hist0 <= {hist0[1:0], sync0[1]};
            hist1 <= {hist1[1:0], sync1[1]};
        end
    end

    assign in0_clean = maj3(hist0);
    assign in1_clean = maj3(hist1);
`else
    assign in0_clean = sync0[1];
    assign in1_clean = sync1[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in0_prev <= 1'b1;
            in1_prev <= 1'b1;
        end else begin
            in0_prev <= in0_clean;
            in1_prev <= in1_clean;
        end
    end

    assign fall0 = in0_prev && !in0_clean;
    assign fall1 = in1_prev && !in1_clean;

    assign cmd = intc_cmd_e'(cmd_op);

    always_comb begin
        c_seie  = 1'b0;
        c_reie  = 1'b0;
        c_seif0 = 1'b0;
        c_reif0 = 1'b0;
        c_seif1 = 1'b0;
        c_reif1 = 1'b0;
        c_setf  = 1'b0;
        c_retf  = 1'b0;
        c_secf  = 1'b0;
        c_recf  = 1'b0;
        c_seim  = 1'b0;
        c_reim  = 1'b0;
        c_load  = 1'b0;
        if (ce && cmd_valid) begin
            case (cmd)
                CMD_SEIE:         c_seie  = 1'b1;
                CMD_REIE:         c_reie  = 1'b1;
                CMD_SEIF0:        c_seif0 = 1'b1;
                CMD_REIF0:        c_reif0 = 1'b1;
                CMD_SEIF1:        c_seif1 = 1'b1;
                CMD_REIF1:        c_reif1 = 1'b1;
                CMD_SETF:         c_setf  = 1'b1;
                CMD_RETF:         c_retf  = 1'b1;
                CMD_SECF:         c_secf  = 1'b1;
                CMD_RECF:         c_recf  = 1'b1;
                CMD_SEIM:         c_seim  = 1'b1;
                CMD_REIM:         c_reim  = 1'b1;
                CMD_LTI, CMD_LTA: c_load  = 1'b1;
                default:          ;
            endcase
        end
    end

    hmcs_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .cf       (cf),
        .cnt_edge (fall1),
        .load     (c_load),
        .load_data(cmd_data),
        .counter  (counter),
        .ovf      (tmr_ovf)
    );

    assign pend     = {tf, if1, if0} & ~{tm, im1, im0};
    assign ack_take = (state == ST_PEND) && irq_ack;
    assign svc_exit = (state == ST_SERVICE) && ((ce && rtni) || c_seie);
    assign ack_clr  = ack_take ? (3'b001 << winner) : 3'b000;

    always_comb begin
        win_src = SRC_INT0;
        win_vec = VEC_INT0;
        if (pend[0]) begin
            win_src = SRC_INT0;
            win_vec = VEC_INT0;
        end else if (pend[1]) begin
            win_src = SRC_INT1;
            win_vec = VEC_INT1;
        end else if (pend[2]) begin
            win_src = SRC_TIMER;
            win_vec = VEC_TIMER;
        end
    end

    // Hardware sets are applied last so they survive a same-cycle software or ack clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if0 <= 1'b0;
            if1 <= 1'b0;
            tf  <= 1'b0;
            im0 <= 1'b1;
            im1 <= 1'b1;
            tm  <= 1'b1;
            ie  <= 1'b0;
            cf  <= 1'b0;
        end else begin
            if (c_seif0)
                if0 <= 1'b1;
            else if (c_reif0 || ack_clr[0])
                if0 <= 1'b0;
            if (fall0)
                if0 <= 1'b1;

            if (c_seif1)
                if1 <= 1'b1;
            else if (c_reif1 || ack_clr[1])
                if1 <= 1'b0;
            if (fall1)
                if1 <= 1'b1;

            if (c_setf)
                tf <= 1'b1;
            else if (c_retf || ack_clr[2])
                tf <= 1'b0;
            if (tmr_ovf)
                tf <= 1'b1;

            if (c_seim || c_reim) begin
                case (cmd_data[1:0])
                    SRC_INT0:  im0 <= c_seim;
                    SRC_INT1:  im1 <= c_seim;
                    SRC_TIMER: tm  <= c_seim;
                    default:   ;
                endcase
            end

            if (c_secf)
                cf <= 1'b1;
            else if (c_recf)
                cf <= 1'b0;

            if (c_seie)
                ie <= 1'b1;
            else if (c_reie)
                ie <= 1'b0;
            if (ack_take)
                ie <= 1'b0;
            else if (svc_exit)
                ie <= 1'b1;
        end
    end

    // The winner and vector are latched on entry to PEND and frozen until ack or withdraw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            irq     <= 1'b0;
            irq_vec <= VEC_INT0;
            winner  <= SRC_INT0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ie && (|pend)) begin
                        winner  <= win_src;
                        irq_vec <= win_vec;
                        irq     <= 1'b1;
                        state   <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (irq_ack) begin
                        irq   <= 1'b0;
                        state <= ST_SERVICE;
                    end else if (c_reie) begin
                        irq   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (svc_exit)
                        state <= ST_IDLE;
                end
                default: begin
                    irq   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign flags = {ie, tm, im1, im0, cf};
    assign req   = {tf, if1, if0};

endmodule

// File: tb/tb_hmcs_intc.sv
// Scoreboard bench for hmcs_intc: expected irq vectors are queued by the stimulus
// and checked by a monitor on each irq rise; status outputs are checked directly.
module tb_hmcs_intc;
    import hmcs_pkg::*;

    localparam logic [10:0] VEC0 = 11'h03F;
    localparam logic [10:0] VEC1 = 11'h0BF;
    localparam logic [10:0] VECT = 11'h13F;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        int0;
    logic        int1;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_data;
    logic [3:0]  counter;
    logic [4:0]  flags;
    logic [2:0]  req;
    logic        irq;
    logic [10:0] irq_vec;
    logic        irq_ack;
    logic        rtni;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [10:0] exp_q[$];
    logic        irq_seen = 1'b0;

    hmcs_intc #(
        .PRESCALE_W(6),
        .VEC_INT0  (VEC0),
        .VEC_INT1  (VEC1),
        .VEC_TIMER (VECT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .int0     (int0),
        .int1     (int1),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .counter  (counter),
        .flags    (flags),
        .req      (req),
        .irq      (irq),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .rtni     (rtni)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: every rising irq must match the oldest queued vector.
    always @(negedge clk) begin
        logic [10:0] e;
        if (irq && !irq_seen) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_irq: got vec %h, expected no irq", irq_vec);
            end else begin
                e = exp_q.pop_front();
                if (irq_vec !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL irq_vec: got %h, expected %h", irq_vec, e);
                end
            end
        end
        irq_seen = irq;
    end

    task automatic check_output(input string name, input logic [10:0] actual,
                                input logic [10:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_cmd(input logic [3:0] op, input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_data  = 4'h0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!irq) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: got irq=0 after %0d cycles, expected irq=1", name, n);
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; int0 = 1'b1; int1 = 1'b1;
        cmd_valid = 1'b0; cmd_op = 4'h0; cmd_data = 4'h0;
        irq_ack = 1'b0; rtni = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_counter", counter, 11'h0);
        check_output("reset_flags", flags, 11'b01110);
        check_output("reset_req", req, 11'h0);
        check_output("reset_irq", irq, 11'h0);
        check_output("reset_vec", irq_vec, VEC0);
        reset = 1'b0;
        @(negedge clk);

        // Timer: load E, F after 64 ce, wrap with tf after 128 ce.
        apply_cmd(CMD_LTI, 4'hE);
        check_output("lti_load", counter, 11'hE);
        repeat (63) @(negedge clk);
        check_output("pre_tick_63", counter, 11'hE);
        @(negedge clk);
        check_output("tick_64", counter, 11'hF);
        check_output("tick_64_tf", req, 11'b000);
        repeat (64) @(negedge clk);
        check_output("wrap_128", counter, 11'h0);
        check_output("wrap_128_tf", req, 11'b100);
        apply_cmd(CMD_RETF, 4'h0);
        check_output("retf", req, 11'b000);

        // Load collides with a prescaler tick at F: load wins, no tf.
        apply_cmd(CMD_LTI, 4'hF);
        repeat (63) @(negedge clk);
        apply_cmd(CMD_LTA, 4'h5);
        check_output("load_beats_tick", counter, 11'h5);
        check_output("load_beats_tick_tf", req, 11'b000);

        // Commands with ce=0 are ignored.
        ce = 1'b0;
        apply_cmd(CMD_SEIE, 4'h0);
        ce = 1'b1;
        check_output("ce_gated_cmd", flags, 11'b01110);

        // Simultaneous INT0/INT1: INT0 wins, then INT1 after rtni.
        apply_cmd(CMD_REIM, 4'd0);
        apply_cmd(CMD_REIM, 4'd1);
        apply_cmd(CMD_SEIE, 4'h0);
        check_output("unmask_flags", flags, 11'b11000);
        exp_q.push_back(VEC0);
        int0 = 1'b0;
        int1 = 1'b0;
        wait_irq("irq_int0");
        pulse_ack();
        check_output("ack_req", req, 11'b010);
        check_output("ack_flags", flags, 11'b01000);
        check_output("ack_irq", irq, 11'h0);
        int0 = 1'b1;
        int1 = 1'b1;
        exp_q.push_back(VEC1);
        rtni = 1'b1;
        @(negedge clk);
        rtni = 1'b0;
        check_output("rtni_ie", flags, 11'b11000);
        @(negedge clk);
        check_output("irq_latency", irq, 11'h1);

        // PEND on INT1: winner frozen despite tf and INT0 arriving; REIE withdraws.
        apply_cmd(CMD_REIM, 4'd2);
        apply_cmd(CMD_SETF, 4'h0);
        int0 = 1'b0;
        repeat (5) @(negedge clk);
        int0 = 1'b1;
        check_output("frozen_irq", irq, 11'h1);
        check_output("frozen_vec", irq_vec, VEC1);
        check_output("frozen_req", req, 11'b111);
        apply_cmd(CMD_REIE, 4'h0);
        check_output("withdraw_irq", irq, 11'h0);
        check_output("withdraw_req", req, 11'b111);
        check_output("withdraw_flags", flags, 11'b00000);
        apply_cmd(CMD_REIF0, 4'h0);
        apply_cmd(CMD_REIF1, 4'h0);
        apply_cmd(CMD_RETF, 4'h0);
        check_output("clear_all", req, 11'b000);

        // Counter mode: five int1 falling edges, prescaler ticks ignored.
        apply_cmd(CMD_SECF, 4'h0);
        apply_cmd(CMD_LTI, 4'h2);
        for (int i = 0; i < 5; i++) begin
            int1 = 1'b0;
            repeat (3) @(negedge clk);
            int1 = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (70) @(negedge clk);
        check_output("cf_count", counter, 11'h7);
        check_output("cf_req", req, 11'b010);
        check_output("cf_flags", flags, 11'b00001);
        apply_cmd(CMD_REIF1, 4'h0);
        apply_cmd(CMD_LTI, 4'hF);
        int1 = 1'b0;
        repeat (4) @(negedge clk);
        int1 = 1'b1;
        repeat (3) @(negedge clk);
        check_output("cf_overflow", counter, 11'h0);
        check_output("cf_overflow_req", req, 11'b110);
        apply_cmd(CMD_REIF1, 4'h0);
        apply_cmd(CMD_RETF, 4'h0);

        // One-clock low glitch on int0.
        int0 = 1'b0;
        @(negedge clk);
        int0 = 1'b1;
        repeat (6) @(negedge clk);
`ifdef HMCS_INTC_GLITCH_FILTER_EN
        check_output("glitch", req, 11'b000);
`else
        check_output("glitch", req, 11'b001);
`endif
        apply_cmd(CMD_REIF0, 4'h0);
        check_output("glitch_clear", req, 11'b000);

        // Timer source alone gives the timer vector; SEIE leaves SERVICE.
        exp_q.push_back(VECT);
        apply_cmd(CMD_SETF, 4'h0);
        apply_cmd(CMD_SEIE, 4'h0);
        wait_irq("irq_timer");
        pulse_ack();
        check_output("timer_ack_req", req, 11'b000);
        check_output("timer_ack_flags", flags, 11'b00001);
        apply_cmd(CMD_SEIE, 4'h0);
        check_output("seie_service_flags", flags, 11'b10001);
        check_output("seie_service_irq", irq, 11'h0);

        // Asynchronous reset while PEND.
        apply_cmd(CMD_LTI, 4'h9);
        exp_q.push_back(VECT);
        apply_cmd(CMD_SETF, 4'h0);
        wait_irq("irq_before_reset");
        #1 reset = 1'b1;
        #1;
        check_output("midpend_reset_irq", irq, 11'h0);
        check_output("midpend_reset_req", req, 11'h0);
        check_output("midpend_reset_flags", flags, 11'b01110);
        check_output("midpend_reset_counter", counter, 11'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_output("scoreboard_empty", 11'(exp_q.size()), 11'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
